// File: rtl/scr_pkg.sv
// Shared widths and default parameters for the scrambled-stream byte packer.
package scr_pkg;

    localparam int BYTE_W          = 8;
    localparam int CNT_W           = 16;
    localparam int DEF_FIFO_DEPTH  = 4;
    localparam int DEF_ALIGN_DELAY = 2;

    typedef logic [BYTE_W-1:0] byte_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/scr_byte_packer_if.sv
// Byte output stream of the packer: valid/ready handshake carrying one byte.
interface scr_byte_packer_if;
    import scr_pkg::*;

    byte_t out_data;
    logic  out_valid;
    logic  out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/scr_sync_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is accepted only with a same-cycle pop.
module scr_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic             push_accepted,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q;
    logic             pop_ok;

    assign full          = (level_q == LVL_W'(DEPTH));
    assign empty         = (level_q == '0);
    assign pop_ok        = pop && !empty;
    assign push_accepted = push && (!full || pop_ok);
    assign level         = level_q;
    // Head is masked while empty so the output reads zero after reset.
    assign rdata         = empty ? '0 : mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push_accepted) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_accepted) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop_ok)        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push_accepted, pop_ok})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/scr_byte_packer.sv
// Realigns the enable to the delayed serial stream, assembles LSB-first bytes and queues them.
module scr_byte_packer
    import scr_pkg::*;
#(
    parameter int DEPTH       = DEF_FIFO_DEPTH,
    parameter int ALIGN_DELAY = DEF_ALIGN_DELAY
) (
    input  logic                         clk3,
    input  logic                         rst,
    input  logic                         ser_in,
    input  logic                         en_in,
    input  logic                         sof,
    scr_byte_packer_if.master            out_if,
    output logic                         overflow,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output cnt_t                         byte_count
);

    logic  en_d, sof_d;
    logic  [2:0] bit_cnt_q, bit_cnt_d;
    byte_t asm_q, asm_d;
    byte_t push_data;
    logic  push, pop, push_accepted, fifo_full, fifo_empty;
    logic  overflow_q;
    cnt_t  byte_count_q;

    generate
        if (ALIGN_DELAY == 0) begin : g_nodly
            assign en_d  = en_in;
            assign sof_d = sof;
        end else begin : g_dly
            logic [ALIGN_DELAY-1:0] en_dly_q, sof_dly_q;
            always_ff @(posedge clk3) begin
                if (rst) begin
                    en_dly_q  <= '0;
                    sof_dly_q <= '0;
                end else begin
                    en_dly_q  <= ALIGN_DELAY'({en_dly_q, en_in});
                    sof_dly_q <= ALIGN_DELAY'({sof_dly_q, sof});
                end
            end
            assign en_d  = en_dly_q[ALIGN_DELAY-1];
            assign sof_d = sof_dly_q[ALIGN_DELAY-1];
        end
    endgenerate

    always_comb begin
        bit_cnt_d = bit_cnt_q;
        asm_d     = asm_q;
        push      = 1'b0;
        push_data = {ser_in, asm_q[6:0]};
        if (en_d) begin
            if (sof_d) begin
                // Frame start restarts the byte; any partial byte is dropped unpushed.
                asm_d     = {7'b0, ser_in};
                bit_cnt_d = 3'd1;
            end else begin
                asm_d[bit_cnt_q] = ser_in;
                bit_cnt_d        = bit_cnt_q + 3'd1;
                push             = (bit_cnt_q == 3'd7);
            end
        end
    end

    always_ff @(posedge clk3) begin
        if (rst) begin
            bit_cnt_q    <= '0;
            asm_q        <= '0;
            overflow_q   <= 1'b0;
            byte_count_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            asm_q     <= asm_d;
            if (push && !push_accepted) overflow_q   <= 1'b1;
            if (push_accepted)          byte_count_q <= byte_count_q + CNT_W'(1);
        end
    end

    assign pop = out_if.out_valid && out_if.out_ready;

    scr_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (BYTE_W),
        .LVL_W ($clog2(DEPTH + 1))
    ) u_fifo (
        .clk           (clk3),
        .rst           (rst),
        .push          (push),
        .pop           (pop),
        .wdata         (push_data),
        .rdata         (out_if.out_data),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .push_accepted (push_accepted),
        .level         (fifo_level)
    );

    assign out_if.out_valid = !fifo_empty;
    assign overflow         = overflow_q;
    assign byte_count       = byte_count_q;

    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_scr_byte_packer.sv
// Scoreboard bench for scr_byte_packer: main instance with ALIGN_DELAY=2, two alignment instances.
module tb_scr_byte_packer;
    import scr_pkg::*;

    logic clk3 = 1'b0;
    logic rst = 1'b1;
    logic ser_in = 1'b0, en_in = 1'b0, sof = 1'b0;
    always #5 clk3 = ~clk3;

    scr_byte_packer_if m_if ();
    scr_byte_packer_if a0_if ();
    scr_byte_packer_if a3_if ();

    logic       overflow, a0_ovf, a3_ovf;
    logic [2:0] fifo_level, a0_lvl, a3_lvl;
    cnt_t       byte_count, a0_cnt, a3_cnt;

    scr_byte_packer #(.DEPTH(4), .ALIGN_DELAY(2)) dut (
        .clk3(clk3), .rst(rst), .ser_in(ser_in), .en_in(en_in), .sof(sof),
        .out_if(m_if), .overflow(overflow), .fifo_level(fifo_level), .byte_count(byte_count));
    scr_byte_packer #(.DEPTH(4), .ALIGN_DELAY(0)) dut_d0 (
        .clk3(clk3), .rst(rst), .ser_in(ser_in), .en_in(en_in), .sof(sof),
        .out_if(a0_if), .overflow(a0_ovf), .fifo_level(a0_lvl), .byte_count(a0_cnt));
    scr_byte_packer #(.DEPTH(4), .ALIGN_DELAY(3)) dut_d3 (
        .clk3(clk3), .rst(rst), .ser_in(ser_in), .en_in(en_in), .sof(sof),
        .out_if(a3_if), .overflow(a3_ovf), .fifo_level(a3_lvl), .byte_count(a3_cnt));

    int    chk_cnt = 0;
    int    pass_cnt = 0;
    byte_t exp_q[$];
    byte_t got0[$], got3[$];
    byte_t mon_exp;
    logic  h0 = 1'b0, h1 = 1'b0;

    // Scoreboard: every byte the consumer accepts is compared with the queue head.
    always @(negedge clk3) begin
        if (!rst && m_if.out_valid && m_if.out_ready) begin
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_extra: got %02h, required no byte", m_if.out_data);
            end else begin
                mon_exp = exp_q.pop_front();
                if (m_if.out_data !== mon_exp)
                    $display("FAIL sb_data: got %02h, required %02h", m_if.out_data, mon_exp);
                else begin
                    pass_cnt++;
                    $display("byte out %02h ok", m_if.out_data);
                end
            end
        end
        if (!rst && a0_if.out_valid) got0.push_back(a0_if.out_data);
        if (!rst && a3_if.out_valid) got3.push_back(a3_if.out_data);
    end

    // One cycle of stimulus; the serial bit follows its enable by two cycles.
    task automatic step(input logic en, input logic s, input logic b);
        @(posedge clk3); #1;
        en_in  = en;
        sof    = s;
        ser_in = h1;
        h1     = h0;
        h0     = b;
    endtask

    task automatic send_bits(input byte_t b, input logic sof_first);
        for (int i = 0; i < 8; i++) step(1'b1, sof_first && (i == 0), b[i]);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(posedge clk3); #1;
        rst = 1'b1; en_in = 1'b0; sof = 1'b0; ser_in = 1'b0; h0 = 1'b0; h1 = 1'b0;
        exp_q.delete();
        @(posedge clk3); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        m_if.out_ready = 1'b0;
        do_reset();
        @(negedge clk3);
        chk_cnt++; if (m_if.out_valid !== 1'b0) $display("FAIL rst_valid: got %b, required 0", m_if.out_valid); else pass_cnt++;
        chk_cnt++; if (m_if.out_data !== 8'h00) $display("FAIL rst_data: got %02h, required 00", m_if.out_data); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf: got %b, required 0", overflow); else pass_cnt++;
        chk_cnt++; if (fifo_level !== 3'd0) $display("FAIL rst_level: got %0d, required 0", fifo_level); else pass_cnt++;
        chk_cnt++; if (byte_count !== 16'd0) $display("FAIL rst_count: got %0d, required 0", byte_count); else pass_cnt++;
    endtask

    task automatic test_basic();
        byte_t b = 8'hA5;
        m_if.out_ready = 1'b0;
        do_reset();
        exp_q.push_back(b);
        for (int i = 0; i <= 10; i++) begin
            if (i < 8) step(1'b1, i == 0, b[i]);
            else       step(1'b0, 1'b0, 1'b0);
            @(negedge clk3);
            if (i == 9) begin
                chk_cnt++; if (m_if.out_valid !== 1'b0) $display("FAIL basic_early: got valid=%b at t0+9, required 0", m_if.out_valid); else pass_cnt++;
            end
            if (i == 10) begin
                chk_cnt++; if (m_if.out_valid !== 1'b1) $display("FAIL basic_valid: got valid=%b at t0+10, required 1", m_if.out_valid); else pass_cnt++;
                chk_cnt++; if (m_if.out_data !== 8'hA5) $display("FAIL basic_data: got %02h, required a5", m_if.out_data); else pass_cnt++;
                chk_cnt++; if (byte_count !== 16'd1) $display("FAIL basic_count: got %0d, required 1", byte_count); else pass_cnt++;
            end
        end
        m_if.out_ready = 1'b1;
        idle(3);
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL basic_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_overflow();
        m_if.out_ready = 1'b0;
        do_reset();
        for (int v = 1; v <= 5; v++) begin
            send_bits(byte_t'(v), 1'b0);
            if (v <= 4) exp_q.push_back(byte_t'(v));
        end
        idle(3);
        @(negedge clk3);
        chk_cnt++; if (fifo_level !== 3'd4) $display("FAIL ovf_level: got %0d, required 4", fifo_level); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag: got %b, required 1", overflow); else pass_cnt++;
        chk_cnt++; if (byte_count !== 16'd4) $display("FAIL ovf_count: got %0d, required 4", byte_count); else pass_cnt++;
        m_if.out_ready = 1'b1;
        idle(6);
        @(negedge clk3);
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL ovf_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
        chk_cnt++; if (fifo_level !== 3'd0) $display("FAIL ovf_empty: got %0d, required 0", fifo_level); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_sticky: got %b, required 1", overflow); else pass_cnt++;
    endtask

    task automatic test_sof_discard();
        m_if.out_ready = 1'b1;
        do_reset();
        repeat (3) step(1'b1, 1'b0, 1'b1);
        send_bits(8'h3C, 1'b1);
        exp_q.push_back(8'h3C);
        idle(4);
        @(negedge clk3);
        chk_cnt++; if (byte_count !== 16'd1) $display("FAIL sof_count: got %0d, required 1", byte_count); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL sof_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_full_pop();
        m_if.out_ready = 1'b0;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            send_bits(byte_t'(8'h10 + k), 1'b0);
            exp_q.push_back(byte_t'(8'h10 + k));
        end
        send_bits(8'h77, 1'b0);
        exp_q.push_back(8'h77);
        idle(2);
        // Eighth bit of 0x77 is sampled in this cycle: pop alongside the push.
        m_if.out_ready = 1'b1;
        idle(1);
        m_if.out_ready = 1'b0;
        @(negedge clk3);
        chk_cnt++; if (fifo_level !== 3'd4) $display("FAIL full_level: got %0d, required 4", fifo_level); else pass_cnt++;
        chk_cnt++; if (overflow !== 1'b0) $display("FAIL full_ovf: got %b, required 0", overflow); else pass_cnt++;
        chk_cnt++; if (byte_count !== 16'd5) $display("FAIL full_count: got %0d, required 5", byte_count); else pass_cnt++;
        m_if.out_ready = 1'b1;
        idle(8);
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL full_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        m_if.out_ready = 1'b1;
        do_reset();
        repeat (5) step(1'b1, 1'b0, 1'b1);
        do_reset();
        @(negedge clk3);
        chk_cnt++; if (byte_count !== 16'd0) $display("FAIL rmid_count0: got %0d, required 0", byte_count); else pass_cnt++;
        send_bits(8'hFF, 1'b0);
        exp_q.push_back(8'hFF);
        idle(4);
        @(negedge clk3);
        chk_cnt++; if (byte_count !== 16'd1) $display("FAIL rmid_count: got %0d, required 1", byte_count); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL rmid_drain: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    endtask

    task automatic test_align();
        logic [10:0] p = 11'h5B3;
        m_if.out_ready = 1'b1;
        do_reset();
        got0.delete();
        got3.delete();
        exp_q.push_back(byte_t'(p >> 2));
        // ser_in driven raw: each instance picks the window starting at its own delay.
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk3); #1;
            en_in = (c < 8); sof = (c == 0); ser_in = p[c];
        end
        idle(5);
        @(negedge clk3);
        chk_cnt++; if (got0.size() != 1 || got0[0] !== byte_t'(p)) $display("FAIL align_d0: got %0d bytes first %02h, required 1 byte %02h", got0.size(), (got0.size() > 0) ? got0[0] : 8'h00, byte_t'(p)); else pass_cnt++;
        chk_cnt++; if (got3.size() != 1 || got3[0] !== byte_t'(p >> 3)) $display("FAIL align_d3: got %0d bytes first %02h, required 1 byte %02h", got3.size(), (got3.size() > 0) ? got3[0] : 8'h00, byte_t'(p >> 3)); else pass_cnt++;
        chk_cnt++; if (exp_q.size() != 0) $display("FAIL align_d2: got %0d pending, required 0", exp_q.size()); else pass_cnt++;
    endtask

    initial begin
        a0_if.out_ready = 1'b1;
        a3_if.out_ready = 1'b1;
        m_if.out_ready  = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_reset();
        test_sof_discard();
        test_full_pop();
        test_reset_mid();
        test_align();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/scr_byte_packer.md
SCR_BYTE_PACKER -- requirements
Module: scr_byte_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 4; output FIFO depth in bytes, power of two, 2..16.
REQ-002 SHALL have parameter ALIGN_DELAY, default 2; cycles between en_in and the matching ser_in bit, legal range 0..3.
REQ-003 SHALL have port clk3, input, 1 bit; clock, all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit; reset, synchronous, active-high.
REQ-005 SHALL have port ser_in, input, 1 bit; scrambled serial bit stream, LSB of each byte first.
REQ-006 SHALL have port en_in, input, 1 bit; same enable that drives the upstream serializer, undelayed.
REQ-007 SHALL have port sof, input, 1 bit; start-of-frame pulse, aligned with en_in.
REQ-008 SHALL have port out_data, output, 8 bits; head-of-FIFO byte.
REQ-009 SHALL have port out_valid, output, 1 bit; FIFO non-empty.
REQ-010 SHALL have port out_ready, input, 1 bit; consumer accept.
REQ-011 SHALL have port overflow, output, 1 bit; sticky byte-dropped flag.
REQ-012 SHALL have port fifo_level, output, $clog2(DEPTH+1) bits; current occupancy.
REQ-013 SHALL have port byte_count, output, 16 bits; accepted-byte counter.

Function
REQ-014 SHALL delay en_in and sof by exactly ALIGN_DELAY cycles (a shift register; no delay when 0), giving en_d and sof_d.
REQ-015 SHALL sample ser_in only in cycles where en_d=1; sof_d without en_d SHALL be ignored.
REQ-016 SHALL keep a 3-bit bit counter 0..7, wrapping 7->0; each sampled bit SHALL be written to position bit_cnt of the assembly byte.
REQ-017 When sof_d=1 and en_d=1, the sampled bit SHALL go to position 0, bit_cnt SHALL become 1, and any partial byte SHALL be discarded without a push.
REQ-018 When the sampled bit has bit_cnt=7, the completed byte {ser_in, assembly[6:0]} SHALL be pushed in that same cycle.
REQ-019 Push latency: if the FIFO was empty, out_valid SHALL assert the cycle after the eighth bit is sampled, with out_data equal to that byte.
REQ-020 Pop SHALL occur when out_valid=1 and out_ready=1; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 When full, a push with a same-cycle pop SHALL be accepted, and fifo_level SHALL stay at DEPTH.
REQ-022 When full, a push with no pop SHALL be dropped and overflow SHALL set; overflow SHALL clear only on rst.
REQ-023 A same-cycle push and pop on an empty FIFO SHALL NOT happen (out_valid=0); the push SHALL succeed.
REQ-024 byte_count SHALL increment on every accepted push, wrapping 16'hFFFF->0; dropped or discarded bytes SHALL NOT count.
REQ-025 fifo_level SHALL equal pushes minus pops and SHALL never exceed DEPTH.

Reset
REQ-026 On rst, all of the following SHALL clear: out_valid=0, out_data=0, overflow=0, fifo_level=0, byte_count=0, bit_cnt=0, assembly byte=0, and both delay lines.
REQ-027 Reset mid-byte SHALL discard the partial byte; the first sampled bit after reset SHALL be bit 0.
REQ-028 Reset SHALL take priority over push, pop and sof in the same cycle.

Structure
REQ-029 Package scr_pkg SHALL hold BYTE_W=8, CNT_W=16, DEF_FIFO_DEPTH=4 and DEF_ALIGN_DELAY=2.
REQ-030 FIFO storage and pointers SHALL be a sub-module named scr_sync_fifo (with full, empty and level outputs); bit assembly, alignment and counters SHALL live in scr_byte_packer.

Verification
REQ-031 ALIGN_DELAY=2, sof+en_in at t0 then en_in for 8 cycles, ser_in carrying 0xA5 LSB-first from t0+2 -> out_valid at t0+10, out_data=0xA5, byte_count=1.
REQ-032 out_ready=0, five consecutive bytes 0x01..0x05 -> fifo_level=4, overflow=1, byte_count=4; then drain -> 0x01,0x02,0x03,0x04.
REQ-033 3 bits, then sof with 0x3C -> only 0x3C emitted, byte_count=1.
REQ-034 FIFO full, out_ready=1 while byte 0x77 completes -> no overflow, level stays 4, and 0x77 is last out.
REQ-035 rst after 5 bits, then 0xFF -> single output 0xFF, byte_count=1.
REQ-036 A single en_in pulse with ALIGN_DELAY=0 and ALIGN_DELAY=3 -> ser_in sampled at t0 and t0+3 respectively.
